// File: rtl/lsu_pkg.sv
// Shared types, encodings and defaults for the load/store unit.
// Imported by the bus interface, the lane aligner and the controller.
package lsu_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int TIMEOUT_DEF    = 255;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [2:0] RSEL_LB  = 3'b000;
  localparam logic [2:0] RSEL_LH  = 3'b001;
  localparam logic [2:0] RSEL_LW  = 3'b010;
  localparam logic [2:0] RSEL_LBU = 3'b100;
  localparam logic [2:0] RSEL_LHU = 3'b101;

  localparam logic [1:0] WSEL_SB = 2'b00;
  localparam logic [1:0] WSEL_SH = 2'b01;
  localparam logic [1:0] WSEL_SW = 2'b10;

  // Unknown size codes fall through to the word rule.
  function automatic logic misaligned(
    input logic       rw,
    input logic [2:0] rsel,
    input logic [1:0] wsel,
    input logic [1:0] lo
  );
    logic byt;
    logic half;
    byt  = rw ? (wsel == WSEL_SB)
              : (rsel == RSEL_LB || rsel == RSEL_LBU);
    half = rw ? (wsel == WSEL_SH)
              : (rsel == RSEL_LH || rsel == RSEL_LHU);
    if (byt)  return 1'b0;
    if (half) return lo[0];
    return lo != 2'b00;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Word-wide memory bus between the LSU (master) and memory (slave).
// Request fields stay stable until the ack is sampled.
interface lsu_if
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  logic                  bus_req;
  logic                  bus_we;
  logic [DATA_WIDTH-1:0] bus_addr;
  logic [DATA_WIDTH-1:0] bus_wdata;
  logic [3:0]            bus_be;
  logic                  bus_ack;
  logic [DATA_WIDTH-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr,
    output bus_wdata, bus_be,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr,
    input  bus_wdata, bus_be,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Store lane steering, load byte/half extraction and extension,
// and the alignment check. Purely combinational.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic [1:0]            addr_lo_i,
  input  logic                  mem_rw_i,
  input  logic [2:0]            rsel_i,
  input  logic [1:0]            wsel_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [1:0]            ld_off_i,
  input  logic [2:0]            ld_rsel_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic [DATA_WIDTH-1:0] st_data_o,
  output logic [3:0]            st_be_o,
  output logic [DATA_WIDTH-1:0] ld_data_o,
  output logic                  misalign_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign misalign_o = misaligned(mem_rw_i, rsel_i,
                                 wsel_i, addr_lo_i);

  always_comb begin
    st_data_o = wdata_i;
    st_be_o   = 4'b1111;
    unique case (wsel_i)
      WSEL_SB: begin
        st_data_o = {4{wdata_i[7:0]}};
        st_be_o   = 4'b0001 << addr_lo_i;
      end
      WSEL_SH: begin
        st_data_o = {2{wdata_i[15:0]}};
        st_be_o   = 4'b0011 << {addr_lo_i[1], 1'b0};
      end
      WSEL_SW: st_be_o = 4'b1111;
      default: st_be_o = 4'b1111;
    endcase
  end

  assign ld_byte = rdata_i[{ld_off_i, 3'b000} +: 8];
  assign ld_half = rdata_i[{ld_off_i[1], 4'b0000} +: 16];

  always_comb begin
    ld_data_o = rdata_i;
    unique case (ld_rsel_i)
      RSEL_LB:  ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      RSEL_LH:  ld_data_o = {{16{ld_half[15]}}, ld_half};
      RSEL_LBU: ld_data_o = {24'd0, ld_byte};
      RSEL_LHU: ld_data_o = {16'd0, ld_half};
      RSEL_LW:  ld_data_o = rdata_i;
      default:  ld_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: IDLE/WAIT/DONE handshake with the memory
// bus, pipeline stall generation and ack timeout.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  mem_rw,
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [2:0]            rsel,
  input  logic [1:0]            wsel,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_valid,
  output logic                  misalign,
  output logic                  bus_err,
  lsu_if.master                 bus
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e                state_q;
  logic [CW-1:0]         cnt_q;
  logic [1:0]            off_q;
  logic [2:0]            rsel_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  valid_q;
  logic                  mis_q;
  logic                  err_q;
  logic                  req_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] baddr_q;
  logic [DATA_WIDTH-1:0] bwdata_q;
  logic [3:0]            be_q;

  logic [DATA_WIDTH-1:0] st_data;
  logic [3:0]            st_be;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  mis;
  logic                  start;
  logic                  timeout;

  lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .addr_lo_i  (addr[1:0]),
    .mem_rw_i   (mem_rw),
    .rsel_i     (rsel),
    .wsel_i     (wsel),
    .wdata_i    (wdata),
    .ld_off_i   (off_q),
    .ld_rsel_i  (rsel_q),
    .rdata_i    (bus.bus_rdata),
    .st_data_o  (st_data),
    .st_be_o    (st_be),
    .ld_data_o  (ld_data),
    .misalign_o (mis)
  );

  assign start   = (state_q == S_IDLE) && req_valid && !mis;
  assign timeout = (cnt_q == CNT_LAST);
  assign stall   = start || (state_q == S_WAIT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      off_q    <= '0;
      rsel_q   <= RSEL_LB;
      rdata_q  <= '0;
      valid_q  <= 1'b0;
      mis_q    <= 1'b0;
      err_q    <= 1'b0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      baddr_q  <= '0;
      bwdata_q <= '0;
      be_q     <= '0;
    end else begin
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (req_valid && mis) mis_q <= 1'b1;
          if (start) begin
            state_q  <= S_WAIT;
            cnt_q    <= '0;
            req_q    <= 1'b1;
            we_q     <= mem_rw;
            baddr_q  <= {addr[DATA_WIDTH-1:2], 2'b00};
            bwdata_q <= mem_rw ? st_data : '0;
            be_q     <= mem_rw ? st_be : 4'b1111;
            off_q    <= addr[1:0];
            rsel_q   <= rsel;
          end
        end
        S_WAIT: begin
          if (bus.bus_ack || timeout) begin
            state_q  <= S_DONE;
            valid_q  <= 1'b1;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            baddr_q  <= '0;
            bwdata_q <= '0;
            be_q     <= '0;
            // ack beats a timeout landing on the same cycle
            if (bus.bus_ack) begin
              if (!we_q) rdata_q <= ld_data;
            end else begin
              err_q   <= 1'b1;
              rdata_q <= '0;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rdata         = rdata_q;
  assign rdata_valid   = valid_q;
  assign misalign      = mis_q;
  assign bus_err       = err_q;
  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = baddr_q;
  assign bus.bus_wdata = bwdata_q;
  assign bus.bus_be    = be_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with TIMEOUT=4.
// Inputs change on the falling edge; outputs are read there too.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        mem_rw;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  rsel;
  logic [1:0]  wsel;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        misalign;
  logic        bus_err;

  int n_cmp = 0;
  int n_err = 0;
  int nreq  = 0;
  logic req_prev = 1'b0;

  lsu_if #(.DATA_WIDTH(32)) bus ();

  lsu_ctrl #(.DATA_WIDTH(32), .TIMEOUT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .mem_rw      (mem_rw),
    .addr        (addr),
    .wdata       (wdata),
    .rsel        (rsel),
    .wsel        (wsel),
    .stall       (stall),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .misalign    (misalign),
    .bus_err     (bus_err),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.bus_req && !req_prev) nreq++;
    req_prev = bus.bus_req;
  end

  task automatic test_reset();
    rst = 1'b0; req_valid = 1'b0; mem_rw = 1'b0;
    addr = '0; wdata = '0; rsel = 3'b010; wsel = 2'b10;
    bus.bus_ack = 1'b0; bus.bus_rdata = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %0h want 0", stall); end
    n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL rst_rdata: got %08h want 00000000", rdata); end
    n_cmp++; if ({rdata_valid, misalign, bus_err} !== 3'b000) begin n_err++; $display("FAIL rst_pulses: got %03b want 000", {rdata_valid, misalign, bus_err}); end
    n_cmp++; if ({bus.bus_req, bus.bus_we, bus.bus_be} !== 6'h0) begin n_err++; $display("FAIL rst_busctl: got %06b want 000000", {bus.bus_req, bus.bus_we, bus.bus_be}); end
    n_cmp++; if ({bus.bus_addr, bus.bus_wdata} !== 64'h0) begin n_err++; $display("FAIL rst_busdata: got %016h want 0", {bus.bus_addr, bus.bus_wdata}); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_lb();
    req_valid = 1'b1; mem_rw = 1'b0; addr = 32'h103; rsel = 3'b000;
    bus.bus_rdata = 32'h80FF_1234;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL lb_stall_idle: got %0h want 1", stall); end
    @(negedge clk);
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL lb_stall_wait: got %0h want 1", stall); end
    n_cmp++; if ({bus.bus_req, bus.bus_we} !== 2'b10) begin n_err++; $display("FAIL lb_req: got %02b want 10", {bus.bus_req, bus.bus_we}); end
    n_cmp++; if (bus.bus_addr !== 32'h100) begin n_err++; $display("FAIL lb_addr: got %08h want 00000100", bus.bus_addr); end
    bus.bus_ack = 1'b1;
    @(negedge clk);
    bus.bus_ack = 1'b0; req_valid = 1'b0;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL lb_stall_done: got %0h want 0", stall); end
    n_cmp++; if (rdata_valid !== 1'b1) begin n_err++; $display("FAIL lb_valid: got %0h want 1", rdata_valid); end
    n_cmp++; if (rdata !== 32'hFFFF_FF80) begin n_err++; $display("FAIL lb_rdata: got %08h want ffffff80", rdata); end
    n_cmp++; if (bus.bus_req !== 1'b0) begin n_err++; $display("FAIL lb_req_drop: got %0h want 0", bus.bus_req); end
    @(negedge clk);
    n_cmp++; if (rdata_valid !== 1'b0) begin n_err++; $display("FAIL lb_valid_pulse: got %0h want 0", rdata_valid); end
  endtask

  task automatic test_store(input logic [1:0] ws, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] exp_a,
                            input logic [31:0] exp_d, input logic [3:0] exp_be);
    req_valid = 1'b1; mem_rw = 1'b1; addr = a; wdata = wd; wsel = ws;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL st_stall: got %0h want 1", stall); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++; if ({bus.bus_req, bus.bus_we} !== 2'b11) begin n_err++; $display("FAIL st_req%0d: got %02b want 11", k, {bus.bus_req, bus.bus_we}); end
      n_cmp++; if (bus.bus_addr !== exp_a) begin n_err++; $display("FAIL st_addr%0d: got %08h want %08h", k, bus.bus_addr, exp_a); end
      n_cmp++; if (bus.bus_wdata !== exp_d) begin n_err++; $display("FAIL st_wdata%0d: got %08h want %08h", k, bus.bus_wdata, exp_d); end
      n_cmp++; if (bus.bus_be !== exp_be) begin n_err++; $display("FAIL st_be%0d: got %04b want %04b", k, bus.bus_be, exp_be); end
    end
    bus.bus_ack = 1'b1;
    @(negedge clk);
    bus.bus_ack = 1'b0; req_valid = 1'b0;
    n_cmp++; if ({rdata_valid, stall, bus.bus_req} !== 3'b100) begin n_err++; $display("FAIL st_done: got %03b want 100", {rdata_valid, stall, bus.bus_req}); end
    @(negedge clk);
  endtask

  task automatic test_load(input logic [2:0] rs, input logic [31:0] a,
                           input logic [31:0] rd, input logic [31:0] exp);
    req_valid = 1'b1; mem_rw = 1'b0; addr = a; rsel = rs;
    bus.bus_rdata = rd;
    @(negedge clk);
    bus.bus_ack = 1'b1;
    @(negedge clk);
    bus.bus_ack = 1'b0; req_valid = 1'b0;
    n_cmp++; if (rdata_valid !== 1'b1) begin n_err++; $display("FAIL ld_valid rsel=%03b: got %0h want 1", rs, rdata_valid); end
    n_cmp++; if (rdata !== exp) begin n_err++; $display("FAIL ld_rdata rsel=%03b: got %08h want %08h", rs, rdata, exp); end
    @(negedge clk);
  endtask

  task automatic test_misalign(input logic rw, input logic [2:0] rs,
                               input logic [1:0] ws, input logic [31:0] a,
                               input logic [31:0] keep);
    int n0;
    n0 = nreq;
    req_valid = 1'b1; mem_rw = rw; addr = a; rsel = rs; wsel = ws;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL mis_stall @%08h: got %0h want 0", a, stall); end
    @(negedge clk);
    req_valid = 1'b0;
    n_cmp++; if (misalign !== 1'b1) begin n_err++; $display("FAIL mis_pulse @%08h: got %0h want 1", a, misalign); end
    n_cmp++; if ({bus.bus_req, stall} !== 2'b00) begin n_err++; $display("FAIL mis_nobus @%08h: got %02b want 00", a, {bus.bus_req, stall}); end
    @(negedge clk);
    n_cmp++; if (misalign !== 1'b0) begin n_err++; $display("FAIL mis_once @%08h: got %0h want 0", a, misalign); end
    n_cmp++; if (rdata !== keep) begin n_err++; $display("FAIL mis_rdata @%08h: got %08h want %08h", a, rdata, keep); end
    n_cmp++; if (nreq !== n0) begin n_err++; $display("FAIL mis_nreq @%08h: got %0d want %0d", a, nreq, n0); end
  endtask

  task automatic test_timeout(input logic ack_last);
    req_valid = 1'b1; mem_rw = 1'b0; addr = 32'h1;
    rsel = ack_last ? 3'b100 : 3'b101;
    addr = ack_last ? 32'h1 : 32'h0;
    bus.bus_rdata = 32'h0000_9A00;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (ack_last && k == 4) bus.bus_ack = 1'b1;
      n_cmp++; if ({stall, bus.bus_req, bus_err} !== 3'b110) begin n_err++; $display("FAIL to_wait%0d ack=%0d: got %03b want 110", k, ack_last, {stall, bus.bus_req, bus_err}); end
    end
    @(negedge clk);
    bus.bus_ack = 1'b0; req_valid = 1'b0;
    n_cmp++; if (bus_err !== !ack_last) begin n_err++; $display("FAIL to_err ack=%0d: got %0h want %0h", ack_last, bus_err, !ack_last); end
    n_cmp++; if (rdata !== (ack_last ? 32'h9A : 32'h0)) begin n_err++; $display("FAIL to_rdata ack=%0d: got %08h want %08h", ack_last, rdata, ack_last ? 32'h9A : 32'h0); end
    n_cmp++; if ({stall, bus.bus_req} !== 2'b00) begin n_err++; $display("FAIL to_done ack=%0d: got %02b want 00", ack_last, {stall, bus.bus_req}); end
    @(negedge clk);
    n_cmp++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL to_err_pulse: got %0h want 0", bus_err); end
  endtask

  task automatic test_reset_wait();
    req_valid = 1'b1; mem_rw = 1'b0; addr = 32'h10; rsel = 3'b010;
    bus.bus_rdata = 32'h1234_5678;
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    n_cmp++; if ({bus.bus_req, rdata_valid, stall} !== 3'b000) begin n_err++; $display("FAIL rw_abandon: got %03b want 000", {bus.bus_req, rdata_valid, stall}); end
    n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL rw_rdata: got %08h want 00000000", rdata); end
    bus.bus_ack = 1'b1;
    @(negedge clk);
    bus.bus_ack = 1'b0;
    @(negedge clk);
    n_cmp++; if ({bus.bus_req, rdata_valid, bus_err, stall} !== 4'b0000) begin n_err++; $display("FAIL rw_stray_ack: got %04b want 0000", {bus.bus_req, rdata_valid, bus_err, stall}); end
    n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL rw_stray_rdata: got %08h want 00000000", rdata); end
  endtask

  task automatic test_back_to_back();
    int n0;
    n0 = nreq;
    req_valid = 1'b1; mem_rw = 1'b1; addr = 32'h40;
    wdata = 32'hDEAD_BEEF; wsel = 2'b10;
    @(negedge clk);
    n_cmp++; if ({bus.bus_be, bus.bus_wdata} !== {4'b1111, 32'hDEAD_BEEF}) begin n_err++; $display("FAIL b2b_sw: got %01h_%08h want f_deadbeef", bus.bus_be, bus.bus_wdata); end
    bus.bus_ack = 1'b1;
    @(negedge clk);
    bus.bus_ack = 1'b0;
    n_cmp++; if ({rdata_valid, stall} !== 2'b10) begin n_err++; $display("FAIL b2b_done1: got %02b want 10", {rdata_valid, stall}); end
    @(negedge clk);
    n_cmp++; if (bus.bus_req !== 1'b0) begin n_err++; $display("FAIL b2b_done_ignores: got %0h want 0", bus.bus_req); end
    mem_rw = 1'b0; addr = 32'h42; rsel = 3'b100;
    bus.bus_rdata = 32'h00AB_0000;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL b2b_stall2: got %0h want 1", stall); end
    @(negedge clk);
    bus.bus_ack = 1'b1;
    @(negedge clk);
    bus.bus_ack = 1'b0; req_valid = 1'b0;
    n_cmp++; if ({rdata_valid, rdata} !== {1'b1, 32'h0000_00AB}) begin n_err++; $display("FAIL b2b_lbu: got %0h/%08h want 1/000000ab", rdata_valid, rdata); end
    repeat (2) @(negedge clk);
    n_cmp++; if (nreq - n0 !== 2) begin n_err++; $display("FAIL b2b_count: got %0d want 2", nreq - n0); end
  endtask

  initial begin
    test_reset();
    test_lb();
    test_store(2'b01, 32'h202, 32'h0000_ABCD, 32'h200, 32'hABCD_ABCD, 4'b1100);
    test_store(2'b00, 32'h003, 32'h0000_0055, 32'h000, 32'h5555_5555, 4'b1000);
    test_store(2'b11, 32'h010, 32'h1357_9BDF, 32'h010, 32'h1357_9BDF, 4'b1111);
    test_load(3'b001, 32'h2, 32'h8001_7FFF, 32'hFFFF_8001);
    test_load(3'b101, 32'h0, 32'h8001_F00D, 32'h0000_F00D);
    test_load(3'b111, 32'h8, 32'h1234_5678, 32'h1234_5678);
    test_misalign(1'b0, 3'b010, 2'b10, 32'h301, 32'h1234_5678);
    test_misalign(1'b1, 3'b010, 2'b01, 32'h201, 32'h1234_5678);
    test_misalign(1'b0, 3'b110, 2'b10, 32'h302, 32'h1234_5678);
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_wait();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
